// File: rtl/algo_4cor1a_c40_cnt_sched.sv
// Counter-command scheduler: per-port request FIFOs, head-address conflict arbitration,
// in-flight command capping and saturating ECC error counters.
module algo_4cor1a_c40_cnt_sched #(
   parameter int unsigned WIDTH   = 64,
   parameter int unsigned BITADDR = 11,
   parameter int unsigned NUMCTPT = 4,
   parameter int unsigned FIFODEP = 4,
   parameter int unsigned BITFIFO = 2,
   parameter int unsigned MAXOUT  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ready,
   input  logic [NUMCTPT-1:0]         rq_vld,
   output logic [NUMCTPT-1:0]         rq_rdy,
   input  logic [NUMCTPT*BITADDR-1:0] rq_adr,
   input  logic [NUMCTPT*WIDTH-1:0]   rq_imm,
   output logic [NUMCTPT-1:0]         cnt,
   output logic [NUMCTPT*BITADDR-1:0] ct_adr,
   output logic [NUMCTPT*WIDTH-1:0]   ct_imm,
   input  logic [NUMCTPT-1:0]         ct_vld,
   input  logic [NUMCTPT-1:0]         ct_serr,
   input  logic [NUMCTPT-1:0]         ct_derr,
   output logic [NUMCTPT-1:0]         busy,
   output logic [15:0]                serr_cnt,
   output logic [15:0]                derr_cnt
);

   localparam int unsigned PW = BITFIFO + 1;
   localparam logic [PW-1:0] FULL_XOR = PW'(1) << BITFIFO;

   logic [PW-1:0]      wr_ptr_q [NUMCTPT];
   logic [PW-1:0]      rd_ptr_q [NUMCTPT];
   logic [PW-1:0]      wr_ptr_d [NUMCTPT];
   logic [PW-1:0]      rd_ptr_d [NUMCTPT];
   logic [3:0]         outst_q  [NUMCTPT];
   logic [3:0]         outst_d  [NUMCTPT];
   logic [BITADDR-1:0] adr_mem  [NUMCTPT][FIFODEP];
   logic [WIDTH-1:0]   imm_mem  [NUMCTPT][FIFODEP];
   logic [BITADDR-1:0] head_adr [NUMCTPT];
   logic [WIDTH-1:0]   head_imm [NUMCTPT];
   logic [NUMCTPT-1:0] empty, full, cand, pop, push, busy_d;
   logic [16:0]        serr_sum, derr_sum;

   always_comb begin
      for (int i = 0; i < NUMCTPT; i++) begin
         empty[i]    = (wr_ptr_q[i] == rd_ptr_q[i]);
         full[i]     = ((wr_ptr_q[i] ^ rd_ptr_q[i]) == FULL_XOR);
         head_adr[i] = adr_mem[i][rd_ptr_q[i][BITFIFO-1:0]];
         head_imm[i] = imm_mem[i][rd_ptr_q[i][BITFIFO-1:0]];
         push[i]     = rq_vld[i] && !full[i];
         // A command registered on cnt but not yet counted is still in flight.
         cand[i]     = ready && !empty[i] &&
                       (({1'b0, outst_q[i]} + {4'b0, cnt[i]}) < 5'(MAXOUT));
      end
      rq_rdy = ~full;
   end

   // The lowest-index candidate for a given address wins; the rest hold.
   always_comb begin
      pop = cand;
      for (int i = 1; i < NUMCTPT; i++) begin
         for (int j = 0; j < i; j++) begin
            if (cand[j] && (head_adr[j] == head_adr[i])) pop[i] = 1'b0;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUMCTPT; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
         outst_d[i]  = outst_q[i];
         if (cnt[i] && !ct_vld[i]) begin
            outst_d[i] = outst_q[i] + 4'd1;
         end else if (!cnt[i] && ct_vld[i] && (outst_q[i] != 4'd0)) begin
            outst_d[i] = outst_q[i] - 4'd1;
         end
         busy_d[i] = (wr_ptr_d[i] != rd_ptr_d[i]) || (outst_d[i] != 4'd0) || pop[i];
      end
   end

   always_comb begin
      serr_sum = {1'b0, serr_cnt};
      derr_sum = {1'b0, derr_cnt};
      for (int i = 0; i < NUMCTPT; i++) begin
         serr_sum = serr_sum + 17'(ct_vld[i] & ct_serr[i]);
         derr_sum = derr_sum + 17'(ct_vld[i] & ct_derr[i]);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUMCTPT; i++) begin
         if (push[i]) begin
            adr_mem[i][wr_ptr_q[i][BITFIFO-1:0]] <= rq_adr[i*BITADDR +: BITADDR];
            imm_mem[i][wr_ptr_q[i][BITFIFO-1:0]] <= rq_imm[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUMCTPT; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            outst_q[i]  <= '0;
         end
         cnt      <= '0;
         ct_adr   <= '0;
         ct_imm   <= '0;
         busy     <= '0;
         serr_cnt <= '0;
         derr_cnt <= '0;
      end else begin
         for (int i = 0; i < NUMCTPT; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            outst_q[i]  <= outst_d[i];
            if (pop[i]) begin
               ct_adr[i*BITADDR +: BITADDR] <= head_adr[i];
               ct_imm[i*WIDTH +: WIDTH]     <= head_imm[i];
            end
         end
         cnt      <= pop;
         busy     <= busy_d;
         serr_cnt <= serr_sum[16] ? 16'hFFFF : serr_sum[15:0];
         derr_cnt <= derr_sum[16] ? 16'hFFFF : derr_sum[15:0];
      end
   end

endmodule

// File: tb/tb_algo_4cor1a_c40_cnt_sched.sv
// Directed bench: a queue-level model predicts every output each cycle, plus literal checks.
module tb_algo_4cor1a_c40_cnt_sched;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ready = 1'b0;
   logic [3:0]    rq_vld = '0;
   logic [3:0]    rq_rdy;
   logic [43:0]   rq_adr = '0;
   logic [255:0]  rq_imm = '0;
   logic [3:0]    cnt;
   logic [43:0]   ct_adr;
   logic [255:0]  ct_imm;
   logic [3:0]    ct_vld = '0;
   logic [3:0]    ct_serr = '0;
   logic [3:0]    ct_derr = '0;
   logic [3:0]    busy;
   logic [15:0]   serr_cnt, derr_cnt;

   algo_4cor1a_c40_cnt_sched dut (
      .clk(clk), .rst(rst), .ready(ready), .rq_vld(rq_vld), .rq_rdy(rq_rdy),
      .rq_adr(rq_adr), .rq_imm(rq_imm), .cnt(cnt), .ct_adr(ct_adr), .ct_imm(ct_imm),
      .ct_vld(ct_vld), .ct_serr(ct_serr), .ct_derr(ct_derr), .busy(busy),
      .serr_cnt(serr_cnt), .derr_cnt(derr_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int pulses0 = 0;

   // Model: each port is a list of pending entries plus a count of issued-but-uncompleted
   // commands; the issued outputs and error totals are tracked directly.
   int          m_n   [4];
   logic [10:0] m_qa  [4][4];
   logic [63:0] m_qi  [4][4];
   int          m_inf [4];
   logic [3:0]  m_cnt;
   logic [10:0] m_la  [4];
   logic [63:0] m_li  [4];
   int          m_serr, m_derr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_n[i] = 0; m_inf[i] = 0; m_la[i] = '0; m_li[i] = '0;
      end
      m_cnt = '0; m_serr = 0; m_derr = 0;
   endtask

   task automatic model_step();
      bit [3:0] cand, pop;
      if (!rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 4; i++) cand[i] = ready && (m_n[i] > 0) && (m_inf[i] < 8);
      pop = cand;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < i; j++)
            if (cand[j] && m_qa[j][0] == m_qa[i][0]) pop[i] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         int done;
         done = (ct_vld[i] && m_inf[i] > 0) ? 1 : 0;
         if (ct_vld[i] && ct_serr[i]) m_serr++;
         if (ct_vld[i] && ct_derr[i]) m_derr++;
         m_inf[i] = m_inf[i] + int'(pop[i]) - done;
         if (pop[i]) begin
            m_la[i] = m_qa[i][0];
            m_li[i] = m_qi[i][0];
            for (int k = 0; k < 3; k++) begin
               m_qa[i][k] = m_qa[i][k+1];
               m_qi[i][k] = m_qi[i][k+1];
            end
         end
         // Fullness is judged before this edge's pop.
         if (rq_vld[i] && m_n[i] < 4) begin
            m_qa[i][m_n[i] - int'(pop[i])] = rq_adr[i*11 +: 11];
            m_qi[i][m_n[i] - int'(pop[i])] = rq_imm[i*64 +: 64];
            m_n[i]++;
         end
         if (pop[i]) m_n[i]--;
      end
      if (m_serr > 65535) m_serr = 65535;
      if (m_derr > 65535) m_derr = 65535;
      m_cnt = pop;
   endtask

   task automatic compare();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rq_rdy[%0d]", i), 64'(rq_rdy[i]), 64'(m_n[i] < 4));
         chk($sformatf("cnt[%0d]", i), 64'(cnt[i]), 64'(m_cnt[i]));
         chk($sformatf("ct_adr[%0d]", i), 64'(ct_adr[i*11 +: 11]), 64'(m_la[i]));
         chk($sformatf("ct_imm[%0d]", i), ct_imm[i*64 +: 64], m_li[i]);
         chk($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(m_n[i] > 0 || m_inf[i] > 0));
      end
      chk("serr_cnt", 64'(serr_cnt), 64'(m_serr));
      chk("derr_cnt", 64'(derr_cnt), 64'(m_derr));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      if (cnt[0]) pulses0++;
   endtask

   task automatic set_req(input int p, input logic [10:0] a, input logic [63:0] v);
      rq_vld[p] = 1'b1;
      rq_adr[p*11 +: 11] = a;
      rq_imm[p*64 +: 64] = v;
   endtask

   initial begin
      int k;
      model_reset();
      tick(); tick();
      chk("reset_cnt", 64'(cnt), 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_rdy", 64'(rq_rdy), 64'hF);
      rst = 1'b1;
      tick();

      // Single issue
      ready = 1'b1;
      set_req(0, 11'h005, 64'd3);
      tick();
      rq_vld = '0;
      tick();
      chk("single_cnt", 64'(cnt), 64'h1);
      chk("single_adr", 64'(ct_adr[10:0]), 64'h005);
      chk("single_imm", ct_imm[63:0], 64'd3);
      tick(); tick();
      chk("single_busy_hold", 64'(busy[0]), 64'h1);
      ct_vld[0] = 1'b1;
      tick();
      ct_vld = '0;
      chk("single_busy_clear", 64'(busy[0]), 64'h0);

      // Full FIFO and backpressure
      ready = 1'b0;
      for (int n = 0; n < 4; n++) begin
         set_req(2, 11'h020 + 11'(n), 64'd100 + 64'(n));
         tick();
      end
      rq_vld = '0;
      chk("full_rdy2", 64'(rq_rdy[2]), 64'h0);
      ready = 1'b1;
      tick();
      chk("drain_rdy2", 64'(rq_rdy[2]), 64'h1);
      chk("drain_first_adr", 64'(ct_adr[32:22]), 64'h020);
      for (int n = 0; n < 4; n++) tick();
      chk("drain_last_imm", ct_imm[191:128], 64'd103);
      ct_vld[2] = 1'b1;
      for (int n = 0; n < 4; n++) tick();
      ct_vld = '0;

      // Address conflict
      ready = 1'b0;
      set_req(0, 11'h011, 64'd7);
      set_req(1, 11'h010, 64'd8);
      set_req(3, 11'h010, 64'd9);
      tick();
      rq_vld = '0;
      ready = 1'b1;
      tick();
      chk("conflict_first", 64'(cnt), 64'b0011);
      tick();
      chk("conflict_second", 64'(cnt), 64'b1000);
      tick();
      ct_vld = 4'b1011;
      tick();
      ct_vld = '0;

      // Outstanding cap
      pulses0 = 0;
      k = 0;
      for (int it = 0; it < 40 && k < 9; it++) begin
         rq_vld = '0;
         if (rq_rdy[0]) begin
            set_req(0, 11'h100 + 11'(k), 64'd1000 + 64'(k));
            k++;
         end
         tick();
      end
      rq_vld = '0;
      chk("cap_all_pushed", 64'(k), 64'd9);
      for (int n = 0; n < 8; n++) tick();
      chk("cap_pulses", 64'(pulses0), 64'd8);
      ct_vld[0] = 1'b1;
      tick();
      ct_vld = '0;
      tick(); tick();
      chk("cap_ninth", 64'(pulses0), 64'd9);
      chk("cap_ninth_adr", 64'(ct_adr[10:0]), 64'h108);
      ct_vld[0] = 1'b1;
      for (int n = 0; n < 10; n++) tick();
      ct_vld = '0;

      // Error counter saturation
      ct_vld = 4'hF;
      ct_serr = 4'hF;
      for (int n = 0; n < 16383; n++) tick();
      ct_serr = 4'b0011;
      ct_derr = 4'b0011;
      tick();
      chk("serr_near", 64'(serr_cnt), 64'hFFFE);
      ct_serr = 4'hF;
      ct_derr = 4'hF;
      tick(); tick();
      chk("serr_sat", 64'(serr_cnt), 64'hFFFF);
      chk("derr_both", 64'(derr_cnt), 64'd10);
      ct_vld = '0; ct_serr = '0; ct_derr = '0;
      tick();

      // Asynchronous reset mid-burst
      ready = 1'b0;
      for (int n = 0; n < 4; n++) begin
         set_req(1, 11'h040 + 11'(n), 64'd50 + 64'(n));
         set_req(2, 11'h050 + 11'(n), 64'd60 + 64'(n));
         tick();
      end
      rq_vld = '0;
      ready = 1'b1;
      tick();
      chk("burst_active", 64'(cnt), 64'b0110);
      rst = 1'b0;
      #1;
      chk("async_cnt", 64'(cnt), 64'h0);
      chk("async_busy", 64'(busy), 64'h0);
      chk("async_adr1", 64'(ct_adr[21:11]), 64'h0);
      chk("async_serr", 64'(serr_cnt), 64'h0);
      model_reset();
      tick();
      rst = 1'b1;
      ct_vld = 4'hF;
      tick();
      ct_vld = '0;
      tick(); tick();
      chk("post_reset_busy", 64'(busy), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/algo_4cor1a_c40_cnt_sched.md
ALGO_4COR1A_C40_CNT_SCHED -- requirements
Module: algo_4cor1a_c40_cnt_sched

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows.
- WIDTH, 64, counter immediate width.
- BITADDR, 11, counter address width.
- NUMCTPT, 4, counter ports.
- FIFODEP, 4, per-port request FIFO depth (power of 2).
- BITFIFO, 2, log2(FIFODEP).
- MAXOUT, 8, maximum in-flight commands per port.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning) SHALL be as follows.
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- ready, in, 1, downstream counter memory ready.
- rq_vld, in, NUMCTPT, per-port request valid.
- rq_rdy, out, NUMCTPT, per-port request accept.
- rq_adr, in, NUMCTPT*BITADDR, per-port counter address.
- rq_imm, in, NUMCTPT*WIDTH, per-port increment.
- cnt, out, NUMCTPT, issued command strobe.
- ct_adr, out, NUMCTPT*BITADDR, issued address.
- ct_imm, out, NUMCTPT*WIDTH, issued increment.
- ct_vld, in, NUMCTPT, completion from memory.
- ct_serr, in, NUMCTPT, single-bit error on completion.
- ct_derr, in, NUMCTPT, double-bit error on completion.
- busy, out, NUMCTPT, port has FIFO entries or in-flight commands.
- serr_cnt, out, 16, saturating single-error count.
- derr_cnt, out, 16, saturating double-error count.

Function
REQ-004 Each port SHALL own an independent FIFODEP-entry FIFO holding {adr, imm}, with read and write pointers of BITFIFO+1 bits.
REQ-005 A request SHALL be accepted when rq_vld[i] && rq_rdy[i]; rq_rdy[i] SHALL be 1 iff FIFO i is not full (combinational from registered state only).
REQ-006 A pop and push on a full FIFO in the same cycle SHALL NOT be allowed; rq_rdy stays 0 when full, regardless of any pop.
REQ-007 A pop and push on an empty FIFO in the same cycle SHALL NOT bypass; the entry becomes issuable the next cycle.
REQ-008 Port i SHALL be eligible when ready=1, FIFO i is non-empty, outstanding[i] < MAXOUT, and no lower-index eligible port has an identical head address.
REQ-009 Address-conflict rule: when several eligible heads share an address, only the lowest-index port issues; the others hold one cycle and are re-evaluated.
REQ-010 Eligible ports SHALL pop their head, and cnt[i], ct_adr[i], ct_imm[i] SHALL be registered outputs, asserted exactly one cycle after the eligibility cycle, with cnt high for one cycle per pop.
REQ-011 When cnt[i]=0, ct_adr[i] and ct_imm[i] SHALL hold their last issued values.
REQ-012 While ready=0, no pops SHALL occur; FIFOs continue to accept until full.
REQ-013 outstanding[i] (4 bits) SHALL follow these rules.
- Increments on cnt[i] and decrements on ct_vld[i].
- Both in the same cycle leaves it unchanged.
- ct_vld[i] with outstanding[i]=0 is ignored (no underflow).
REQ-014 busy[i] SHALL equal (FIFO i non-empty) || (outstanding[i] != 0), registered.
REQ-015 serr_cnt SHALL add popcount(ct_vld & ct_serr) each cycle, and derr_cnt SHALL add popcount(ct_vld & ct_derr) each cycle.
REQ-016 Both error counters SHALL saturate at 16'hFFFF and never wrap.
REQ-017 When ct_serr and ct_derr are both set on one port, both counters SHALL count it.
REQ-018 Pointer wrap: a FIFO SHALL be full when pointers differ only in the MSB, and empty when they are equal.

Reset
REQ-019 On rst=0 (asynchronous), all FIFO pointers, outstanding counters, cnt, ct_adr, ct_imm, busy, serr_cnt and derr_cnt SHALL clear to 0 immediately.
REQ-020 rq_rdy SHALL read all-ones from the first clock edge after reset release.
REQ-021 Reset asserted mid-operation SHALL discard all queued and in-flight state, and completions arriving after reset release SHALL be ignored per REQ-013.

Verification
REQ-022 The bench SHALL cover the following directed scenarios.
- Single issue: ready=1, push port0 adr=0x005 imm=3 at cycle N -> cnt[0]=1, ct_adr=0x005, ct_imm=3 at cycle N+2, busy[0]=1 until ct_vld[0].
- Full/backpressure: ready=0, push 4 requests to port2 -> rq_rdy[2]=0 after the 4th; raise ready -> 4 consecutive cnt[2] pulses in FIFO order, rq_rdy[2]=1 one cycle after the first pop.
- Conflict: ports 1 and 3 heads both adr=0x010 -> cnt[1] issues first, cnt[3] one cycle later; port 0 with adr=0x011 issues alongside port 1.
- Outstanding cap: hold ct_vld=0 and push 9 requests on port0 -> exactly 8 cnt pulses; one ct_vld[0] -> the 9th issues.
- Error saturation: preload serr_cnt near 0xFFFE, then ct_vld=4'hF with ct_serr=4'hF -> serr_cnt=0xFFFF and stays.
- Async reset mid-burst: drop rst between clock edges while cnt is active -> outputs 0 before the next edge, busy=0.
